// File: rtl/sd_block_sequencer.sv
// SD command sequencer: optional card bring-up (CMD0/CMD2/CMD7), then CMD17/CMD24 single-block requests.
// Define SD_SEQ_INIT_EN to include the bring-up sequence after reset; otherwise reset lands directly in IDLE.
module sd_block_sequencer #(
  parameter logic [15:0] RCA            = 16'h0013,
  parameter logic [7:0]  DIV_SLOW       = 8'h23,
  parameter logic [7:0]  DIV_FAST       = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_lba_i,
  output logic        done_o,
  output logic        err_o,
  output logic        init_done_o,
  output logic        init_fail_o,
  output logic        reg_we_o,
  output logic [6:0]  reg_addr_o,
  output logic [7:0]  reg_wdata_o,
  input  logic        reg_ack_i,
  input  logic        host_cmd_done_i,
  input  logic        host_data_done_i,
  input  logic        host_err_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [6:0] ADDR_ARG0   = 7'h00;
  localparam logic [6:0] ADDR_ARG1   = 7'h01;
  localparam logic [6:0] ADDR_ARG2   = 7'h02;
  localparam logic [6:0] ADDR_ARG3   = 7'h03;
  localparam logic [6:0] ADDR_FLAGS  = 7'h04;
  localparam logic [6:0] ADDR_CMD    = 7'h05;
  localparam logic [6:0] ADDR_BLKCNT = 7'h1C;
  localparam logic [6:0] ADDR_CLKDIV = 7'h24;
  localparam logic [6:0] ADDR_SWRST  = 7'h28;

  typedef enum logic [3:0] {
    S_IDLE, S_XFER_ISSUE, S_WAIT_CMD, S_WAIT_DATA, S_DONE
`ifdef SD_SEQ_INIT_EN
    , S_INIT_RST, S_INIT_DIV, S_CMD0, S_CMD2, S_CMD7, S_SET_FAST, S_INIT_FAIL
`endif
  } state_t;

`ifdef SD_SEQ_INIT_EN
  localparam state_t RESET_STATE = S_INIT_RST;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [2:0]       step_q, step_d;
  logic             we_q, we_d;
  logic [6:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             write_q, write_d;
  logic [31:0]      lba_q, lba_d;
  logic             timeout;

  logic        wr_active;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_last;
  state_t      wr_next;
  logic [2:0]  wr_next_step;
  state_t      cmd_ret;
  logic        is_issue;
  logic [7:0]  cmd_idx;
  logic [7:0]  cmd_flags;
  logic [31:0] cmd_arg;

  assign timeout = (cnt_q == CNT_MAX);

  // Describes the register write owed by the current state/step; step 0 of an ISSUE is the block count
  // and is only reached by data commands, so init commands start their ISSUE at step 1.
  always_comb begin
    wr_active    = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    wr_last      = 1'b0;
    wr_next      = S_IDLE;
    wr_next_step = 3'd0;
    cmd_ret      = ret_q;
    is_issue     = 1'b0;
    cmd_idx      = '0;
    cmd_flags    = '0;
    cmd_arg      = '0;
    case (state_q)
      S_XFER_ISSUE: begin
        is_issue  = 1'b1;
        cmd_idx   = write_q ? 8'd24 : 8'd17;
        cmd_flags = write_q ? 8'h80 : 8'h7D;
        cmd_arg   = lba_q;
        cmd_ret   = S_WAIT_DATA;
      end
`ifdef SD_SEQ_INIT_EN
      S_INIT_RST: begin
        wr_active = 1'b1;
        wr_addr   = ADDR_SWRST;
        wr_data   = (step_q == 3'd0) ? 8'h01 : 8'h00;
        wr_last   = (step_q != 3'd0);
        wr_next   = S_INIT_DIV;
      end
      S_INIT_DIV: begin
        wr_active    = 1'b1;
        wr_addr      = ADDR_CLKDIV;
        wr_data      = DIV_SLOW;
        wr_last      = 1'b1;
        wr_next      = S_CMD0;
        wr_next_step = 3'd1;
      end
      S_CMD0: begin
        is_issue  = 1'b1;
        cmd_idx   = 8'd0;
        cmd_flags = 8'h00;
        cmd_ret   = S_CMD2;
      end
      S_CMD2: begin
        is_issue  = 1'b1;
        cmd_idx   = 8'd2;
        cmd_flags = 8'h0A;
        cmd_ret   = S_CMD7;
      end
      S_CMD7: begin
        is_issue  = 1'b1;
        cmd_idx   = 8'd7;
        cmd_flags = 8'h1D;
        cmd_arg   = {RCA, 16'h0000};
        cmd_ret   = S_SET_FAST;
      end
      S_SET_FAST: begin
        wr_active = 1'b1;
        wr_addr   = ADDR_CLKDIV;
        wr_data   = DIV_FAST;
        wr_last   = 1'b1;
        wr_next   = S_IDLE;
      end
`endif
      default: ;
    endcase
    if (is_issue) begin
      wr_active = 1'b1;
      wr_next   = S_WAIT_CMD;
      case (step_q)
        3'd0: begin wr_addr = ADDR_BLKCNT; wr_data = 8'h01;          end
        3'd1: begin wr_addr = ADDR_CMD;    wr_data = cmd_idx;        end
        3'd2: begin wr_addr = ADDR_FLAGS;  wr_data = cmd_flags;      end
        3'd3: begin wr_addr = ADDR_ARG3;   wr_data = cmd_arg[31:24]; end
        3'd4: begin wr_addr = ADDR_ARG2;   wr_data = cmd_arg[23:16]; end
        3'd5: begin wr_addr = ADDR_ARG1;   wr_data = cmd_arg[15:8];  end
        default: begin
          wr_addr = ADDR_ARG0;
          wr_data = cmd_arg[7:0];
          wr_last = 1'b1;
        end
      endcase
    end
  end

  // Write states load a strobe whenever none is pending, which leaves one idle cycle after each ack.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    step_d  = step_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    write_d = write_q;
    lba_d   = lba_q;
    if (wr_active) begin
      if (!we_q) begin
        we_d    = 1'b1;
        addr_d  = wr_addr;
        wdata_d = wr_data;
      end else if (reg_ack_i) begin
        we_d = 1'b0;
        if (wr_last) begin
          state_d = wr_next;
          step_d  = wr_next_step;
          ret_d   = cmd_ret;
          cnt_d   = '0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            write_d = req_write_i;
            lba_d   = req_lba_i;
            err_d   = 1'b0;
            state_d = S_XFER_ISSUE;
            step_d  = 3'd0;
            we_d    = 1'b1;
            addr_d  = ADDR_BLKCNT;
            wdata_d = 8'h01;
          end
        end
        S_WAIT_CMD: begin
          if (host_err_i || timeout) begin
`ifdef SD_SEQ_INIT_EN
            if (ret_q != S_WAIT_DATA) begin
              state_d = S_INIT_FAIL;
            end else
`endif
            begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end
          end else if (host_cmd_done_i) begin
            state_d = ret_q;
            step_d  = 3'd1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_DATA: begin
          if (host_err_i || timeout) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (host_data_done_i) begin
            state_d = S_DONE;
            err_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DONE: state_d = S_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RESET_STATE;
      ret_q   <= S_WAIT_DATA;
      step_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      lba_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      step_q  <= step_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      write_q <= write_d;
      lba_q   <= lba_d;
    end
  end

`ifdef SD_SEQ_INIT_EN
  logic init_done_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      init_done_q <= 1'b0;
    end else if (state_d == S_IDLE) begin
      init_done_q <= 1'b1;
    end
  end

  assign init_done_o = init_done_q;
  assign init_fail_o = (state_q == S_INIT_FAIL);
`else
  logic unused_cfg;
  assign unused_cfg  = ^{RCA, DIV_SLOW, DIV_FAST};
  assign init_done_o = 1'b1;
  assign init_fail_o = 1'b0;
`endif

  assign req_ready_o = (state_q == S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = done_o & err_q;
  assign reg_we_o    = we_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;

endmodule
